// File: rtl/nf_mac10g_tx_arbiter.sv
// rtl/nf_mac10g_tx_arbiter.sv - frame-granular round-robin arbiter in front of the 10G MAC TX stream
//
// Shares one 64-bit AXI-Stream TX master between two requesters. One
// requester is granted per frame (round-robin on ties), the grant is held
// until that frame's tlast handshake, and beats pass through with zero
// added latency.
//
// Optional feature macro: FRAME_GUARD_EN
//   When defined, a beat counter cuts frames longer than MAX_BEATS: beat
//   MAX_BEATS is emitted with tlast=1/tuser=1, io_truncated pulses, and the
//   remainder of the frame is swallowed in DROP. When undefined, frames of
//   any length pass unmodified and io_truncated is tied low.
//
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   io_s0_* / io_s1_*     requester streams (tdata/tkeep/tvalid/tlast/tuser in, tready out)
//   io_m_*                master stream to the MAC tx_axis (tready in, rest out)
//   io_grant              one-hot current owner, 00 when nobody is granted
//   io_truncated          one-cycle pulse on the handshake of a guard-cut beat

module nf_mac10g_tx_arbiter #(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = 8,
  parameter int MAX_BEATS = 190
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [DATA_W-1:0] io_s0_tdata,
  input  logic [KEEP_W-1:0] io_s0_tkeep,
  input  logic              io_s0_tvalid,
  output logic              io_s0_tready,
  input  logic              io_s0_tlast,
  input  logic              io_s0_tuser,

  input  logic [DATA_W-1:0] io_s1_tdata,
  input  logic [KEEP_W-1:0] io_s1_tkeep,
  input  logic              io_s1_tvalid,
  output logic              io_s1_tready,
  input  logic              io_s1_tlast,
  input  logic              io_s1_tuser,

  output logic [DATA_W-1:0] io_m_tdata,
  output logic [KEEP_W-1:0] io_m_tkeep,
  output logic              io_m_tvalid,
  input  logic              io_m_tready,
  output logic              io_m_tlast,
  output logic              io_m_tuser,

  output logic [1:0]        io_grant,
  output logic              io_truncated
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1
`ifdef FRAME_GUARD_EN
    ,
    DROP = 2'd2
`endif
  } state_t;

  state_t state, stateNext;

  // grantee/last hold a port index: 0 = s0, 1 = s1.
  logic grantee, granteeNext;
  logic last, lastNext;

  // Granted requester's stream, selected by the registered grantee.
  logic [DATA_W-1:0] selData;
  logic [KEEP_W-1:0] selKeep;
  logic              selValid;
  logic              selLast;
  logic              selUser;

  logic mHandshake;
  logic truncCond;

  assign selData  = grantee ? io_s1_tdata  : io_s0_tdata;
  assign selKeep  = grantee ? io_s1_tkeep  : io_s0_tkeep;
  assign selValid = grantee ? io_s1_tvalid : io_s0_tvalid;
  assign selLast  = grantee ? io_s1_tlast  : io_s0_tlast;
  assign selUser  = grantee ? io_s1_tuser  : io_s0_tuser;

  assign mHandshake = (state == PASS) && selValid && io_m_tready;

`ifdef FRAME_GUARD_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  // Number of beats of the current frame already handed to the MAC.
  logic [CNT_W-1:0] beatCnt;

  // Beat MAX_BEATS is on the bus and the requester did not end the frame
  // there: this beat becomes the forced, errored end of frame.
  assign truncCond = (state == PASS) &&
                     (beatCnt == CNT_W'(MAX_BEATS - 1)) && !selLast;

  always_ff @(posedge clock) begin
    if (reset || (stateNext == IDLE)) begin
      beatCnt <= '0;
    end else if (mHandshake) begin
      beatCnt <= beatCnt + 1'b1;
    end
  end
`else
  assign truncCond = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      grantee <= 1'b0;
      last    <= 1'b1;
    end else begin
      state   <= stateNext;
      grantee <= granteeNext;
      last    <= lastNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext   = state;
    granteeNext = grantee;
    lastNext    = last;
    case (state)
      IDLE: begin
        if (io_s0_tvalid || io_s1_tvalid) begin
          stateNext = PASS;
          // On a tie the port that was not served last wins.
          granteeNext = (io_s0_tvalid && io_s1_tvalid) ? ~last : io_s1_tvalid;
        end
      end
      PASS: begin
        if (mHandshake) begin
`ifdef FRAME_GUARD_EN
          if (truncCond) begin
            stateNext = DROP;
          end else
`endif
          if (selLast) begin
            stateNext = IDLE;
            lastNext  = grantee;
          end
        end
      end
`ifdef FRAME_GUARD_EN
      DROP: begin
        // tready is forced high here, so a valid beat is always consumed.
        if (selValid && selLast) begin
          stateNext = IDLE;
          lastNext  = grantee;
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    io_s0_tready = 1'b0;
    io_s1_tready = 1'b0;
    io_m_tdata   = '0;
    io_m_tkeep   = '0;
    io_m_tvalid  = 1'b0;
    io_m_tlast   = 1'b0;
    io_m_tuser   = 1'b0;
    io_grant     = 2'b00;
    io_truncated = 1'b0;
    case (state)
      PASS: begin
        io_m_tdata  = selData;
        io_m_tkeep  = selKeep;
        io_m_tvalid = selValid;
        io_m_tlast  = selLast | truncCond;
        io_m_tuser  = selUser | truncCond;
        io_grant    = grantee ? 2'b10 : 2'b01;
        if (grantee) io_s1_tready = io_m_tready;
        else         io_s0_tready = io_m_tready;
        io_truncated = mHandshake && truncCond;
      end
`ifdef FRAME_GUARD_EN
      DROP: begin
        io_grant = grantee ? 2'b10 : 2'b01;
        if (grantee) io_s1_tready = 1'b1;
        else         io_s0_tready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nf_mac10g_tx_arbiter.sv
// tb/tb_nf_mac10g_tx_arbiter.sv - directed self-checking bench for nf_mac10g_tx_arbiter

module tb_nf_mac10g_tx_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int MB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] io_s0_tdata, io_s1_tdata, io_m_tdata;
  logic [KW-1:0] io_s0_tkeep, io_s1_tkeep, io_m_tkeep;
  logic          io_s0_tvalid, io_s1_tvalid, io_m_tvalid;
  logic          io_s0_tready, io_s1_tready, io_m_tready;
  logic          io_s0_tlast, io_s1_tlast, io_m_tlast;
  logic          io_s0_tuser, io_s1_tuser, io_m_tuser;
  logic [1:0]    io_grant;
  logic          io_truncated;

  nf_mac10g_tx_arbiter #(.DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(MB)) dut (
    .clock(clock), .reset(reset),
    .io_s0_tdata(io_s0_tdata), .io_s0_tkeep(io_s0_tkeep), .io_s0_tvalid(io_s0_tvalid),
    .io_s0_tready(io_s0_tready), .io_s0_tlast(io_s0_tlast), .io_s0_tuser(io_s0_tuser),
    .io_s1_tdata(io_s1_tdata), .io_s1_tkeep(io_s1_tkeep), .io_s1_tvalid(io_s1_tvalid),
    .io_s1_tready(io_s1_tready), .io_s1_tlast(io_s1_tlast), .io_s1_tuser(io_s1_tuser),
    .io_m_tdata(io_m_tdata), .io_m_tkeep(io_m_tkeep), .io_m_tvalid(io_m_tvalid),
    .io_m_tready(io_m_tready), .io_m_tlast(io_m_tlast), .io_m_tuser(io_m_tuser),
    .io_grant(io_grant), .io_truncated(io_truncated)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    logic [1:0]  g;
  } beat_t;

  typedef struct packed {
    logic [1:0] g;
    logic       r0;
    logic       r1;
    logic       mv;
  } cyc_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t obs[$];
  cyc_t  trace[$];
  logic  readyPat[$];
  int    truncCnt;
  int    checks   = 0;
  int    failures = 0;

  function automatic beat_t mk(input logic [7:0] b, input logic [7:0] k,
                               input logic l, input logic u);
    beat_t x;
    x.d = {8{b}};
    x.k = k;
    x.l = l;
    x.u = u;
    x.g = 2'b00;
    return x;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    obs.delete();
    trace.delete();
    readyPat.delete();
    truncCnt = 0;
  endtask

  // One iteration per clock: drive queue heads, sample mid-cycle, pop on handshake.
  task automatic runCycles(input int n);
    logic  h0, h1;
    beat_t b;
    cyc_t  c;
    for (int i = 0; i < n; i++) begin
      io_m_tready = (readyPat.size() > 0) ? readyPat.pop_front() : 1'b1;
      if (q0.size() > 0) begin
        io_s0_tvalid = 1'b1; io_s0_tdata = q0[0].d; io_s0_tkeep = q0[0].k;
        io_s0_tlast = q0[0].l; io_s0_tuser = q0[0].u;
      end else begin
        io_s0_tvalid = 1'b0; io_s0_tdata = '0; io_s0_tkeep = '0;
        io_s0_tlast = 1'b0; io_s0_tuser = 1'b0;
      end
      if (q1.size() > 0) begin
        io_s1_tvalid = 1'b1; io_s1_tdata = q1[0].d; io_s1_tkeep = q1[0].k;
        io_s1_tlast = q1[0].l; io_s1_tuser = q1[0].u;
      end else begin
        io_s1_tvalid = 1'b0; io_s1_tdata = '0; io_s1_tkeep = '0;
        io_s1_tlast = 1'b0; io_s1_tuser = 1'b0;
      end
      #1;
      c.g = io_grant; c.r0 = io_s0_tready; c.r1 = io_s1_tready; c.mv = io_m_tvalid;
      trace.push_back(c);
      if (io_m_tvalid && io_m_tready) begin
        b.d = io_m_tdata; b.k = io_m_tkeep; b.l = io_m_tlast; b.u = io_m_tuser; b.g = io_grant;
        obs.push_back(b);
      end
      if (io_truncated) truncCnt++;
      h0 = io_s0_tvalid && io_s0_tready;
      h1 = io_s1_tvalid && io_s1_tready;
      @(posedge clock);
      #1;
      if (h0) void'(q0.pop_front());
      if (h1) void'(q1.pop_front());
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    io_s0_tvalid = 1'b0; io_s1_tvalid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [7:0] expB[6];
  logic [1:0] expG[6];
  logic       expR[6];

  initial begin
    io_s0_tdata = '0; io_s0_tkeep = '0; io_s0_tvalid = 1'b0; io_s0_tlast = 1'b0; io_s0_tuser = 1'b0;
    io_s1_tdata = '0; io_s1_tkeep = '0; io_s1_tvalid = 1'b0; io_s1_tlast = 1'b0; io_s1_tuser = 1'b0;
    io_m_tready = 1'b1;
    truncCnt = 0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkVal("rst_s0_tready", io_s0_tready, 0);
    checkVal("rst_s1_tready", io_s1_tready, 0);
    checkVal("rst_m_tvalid", io_m_tvalid, 0);
    checkVal("rst_m_tdata", io_m_tdata, 0);
    checkVal("rst_m_tlast", io_m_tlast, 0);
    checkVal("rst_grant", io_grant, 0);
    checkVal("rst_truncated", io_truncated, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single requester, 3-beat frame
    clearLog();
    q0.push_back(mk(8'h11, 8'hFF, 1'b0, 1'b0));
    q0.push_back(mk(8'h22, 8'hFF, 1'b0, 1'b1));
    q0.push_back(mk(8'h33, 8'h0F, 1'b1, 1'b0));
    runCycles(6);
    checkVal("single_grant_c0", trace[0].g, 2'b00);
    checkVal("single_mvalid_c0", trace[0].mv, 0);
    checkVal("single_grant_c1", trace[1].g, 2'b01);
    checkVal("single_grant_c3", trace[3].g, 2'b01);
    checkVal("single_grant_c4", trace[4].g, 2'b00);
    checkVal("single_nbeats", obs.size(), 3);
    checkVal("single_d0", obs[0].d, 64'h1111111111111111);
    checkVal("single_d1", obs[1].d, 64'h2222222222222222);
    checkVal("single_d2", obs[2].d, 64'h3333333333333333);
    checkVal("single_keep2", obs[2].k, 8'h0F);
    checkVal("single_last1", obs[1].l, 0);
    checkVal("single_last2", obs[2].l, 1);
    checkVal("single_user0", obs[0].u, 0);
    checkVal("single_user1", obs[1].u, 1);

    // Contention: both hold frames after reset, s0 wins first, then alternate
    doReset();
    clearLog();
    q0.push_back(mk(8'hA1, 8'hFF, 1'b0, 1'b0));
    q0.push_back(mk(8'hA2, 8'hFF, 1'b1, 1'b0));
    q0.push_back(mk(8'hC1, 8'hFF, 1'b0, 1'b0));
    q0.push_back(mk(8'hC2, 8'hFF, 1'b1, 1'b0));
    q1.push_back(mk(8'hB1, 8'hFF, 1'b0, 1'b0));
    q1.push_back(mk(8'hB2, 8'hFF, 1'b1, 1'b0));
    runCycles(10);
    expB = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2};
    expG = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    checkVal("cont_nbeats", obs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      checkVal($sformatf("cont_data%0d", i), obs[i].d, {8{expB[i]}});
      checkVal($sformatf("cont_grant%0d", i), obs[i].g, expG[i]);
    end
    checkVal("cont_bubble1", trace[3].g, 2'b00);
    checkVal("cont_bubble2", trace[6].g, 2'b00);

    // Backpressure on a 4-beat s1 frame: ready 1,0,0,1 from the first beat
    clearLog();
    q1.push_back(mk(8'hD1, 8'hFF, 1'b0, 1'b0));
    q1.push_back(mk(8'hD2, 8'hFF, 1'b0, 1'b0));
    q1.push_back(mk(8'hD3, 8'hFF, 1'b0, 1'b0));
    q1.push_back(mk(8'hD4, 8'h03, 1'b1, 1'b0));
    readyPat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    runCycles(8);
    expR = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 1; i < 6; i++) begin
      checkVal($sformatf("bp_s1_tready_c%0d", i), trace[i].r1, expR[i]);
      checkVal($sformatf("bp_s0_tready_c%0d", i), trace[i].r0, 0);
    end
    checkVal("bp_nbeats", obs.size(), 4);
    for (int i = 0; i < 4; i++) checkVal($sformatf("bp_data%0d", i), obs[i].d, {8{8'hD1 + 8'(i)}});
    checkVal("bp_keep3", obs[3].k, 8'h03);
    checkVal("bp_grant_c6", trace[6].g, 2'b10);
    checkVal("bp_grant_c7", trace[7].g, 2'b00);

    // 6-beat s0 frame with s1 pending
    doReset();
    clearLog();
    for (int i = 0; i < 6; i++) q0.push_back(mk(8'hE1 + 8'(i), 8'hFF, (i == 5), 1'b0));
    q1.push_back(mk(8'hF1, 8'hFF, 1'b1, 1'b0));
    runCycles(10);
`ifdef FRAME_GUARD_EN
    checkVal("guard_nbeats", obs.size(), 5);
    checkVal("guard_d3", obs[3].d, {8{8'hE4}});
    checkVal("guard_last3", obs[3].l, 1);
    checkVal("guard_user3", obs[3].u, 1);
    checkVal("guard_user2", obs[2].u, 0);
    checkVal("guard_trunc_cnt", truncCnt, 1);
    checkVal("guard_drop_mvalid5", trace[5].mv, 0);
    checkVal("guard_drop_ready5", trace[5].r0, 1);
    checkVal("guard_drop_mvalid6", trace[6].mv, 0);
    checkVal("guard_drop_grant6", trace[6].g, 2'b01);
    checkVal("guard_s0_drained", q0.size(), 0);
    checkVal("guard_next_d", obs[4].d, {8{8'hF1}});
    checkVal("guard_next_grant", obs[4].g, 2'b10);
`else
    checkVal("long_nbeats", obs.size(), 7);
    checkVal("long_d3", obs[3].d, {8{8'hE4}});
    checkVal("long_last3", obs[3].l, 0);
    checkVal("long_user3", obs[3].u, 0);
    checkVal("long_last5", obs[5].l, 1);
    checkVal("long_d5", obs[5].d, {8{8'hE6}});
    checkVal("long_trunc_cnt", truncCnt, 0);
    checkVal("long_next_d", obs[6].d, {8{8'hF1}});
    checkVal("long_next_grant", obs[6].g, 2'b10);
`endif

    // Exact-length 4-beat frame: tlast on beat MAX_BEATS passes unmodified
    clearLog();
    for (int i = 0; i < 4; i++) q0.push_back(mk(8'h51 + 8'(i), 8'hFF, (i == 3), 1'b0));
    runCycles(7);
    checkVal("exact_nbeats", obs.size(), 4);
    checkVal("exact_last3", obs[3].l, 1);
    checkVal("exact_user3", obs[3].u, 0);
    checkVal("exact_trunc_cnt", truncCnt, 0);

    // Reset after beat 2 of a 5-beat frame, then a tie goes to s0
    clearLog();
    for (int i = 0; i < 5; i++) q0.push_back(mk(8'h61 + 8'(i), 8'hFF, (i == 4), 1'b0));
    runCycles(3);
    checkVal("mid_nbeats", obs.size(), 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkVal("mid_rst_grant", io_grant, 2'b00);
    checkVal("mid_rst_mvalid", io_m_tvalid, 0);
    checkVal("mid_rst_s0_tready", io_s0_tready, 0);
    checkVal("mid_rst_mdata", io_m_tdata, 0);
    checkVal("mid_rst_mtlast", io_m_tlast, 0);
    checkVal("mid_rst_mtuser", io_m_tuser, 0);
    checkVal("mid_rst_mtkeep", io_m_tkeep, 0);
    reset = 1'b0;
    q0.delete();
    clearLog();
    q0.push_back(mk(8'h71, 8'hFF, 1'b1, 1'b0));
    q1.push_back(mk(8'h81, 8'hFF, 1'b1, 1'b0));
    runCycles(6);
    checkVal("tie_nbeats", obs.size(), 2);
    checkVal("tie_first_d", obs[0].d, {8{8'h71}});
    checkVal("tie_first_grant", obs[0].g, 2'b01);
    checkVal("tie_second_d", obs[1].d, {8{8'h81}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
